// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver
//
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity bit,
// one stop bit (1). Each bit spans Prescale clock cycles (8 or 16).
//
// Ports
//   CLK          in   1   clock, rising edge
//   Reset        in   1   asynchronous active-low reset
//   S_Data       in   1   serial line, idles high, synchronous to CLK
//   Parity_EN    in   1   1 = frame carries a parity bit
//   Parity_type  in   1   0 = even, 1 = odd
//   Prescale     in   5   clock cycles per bit (8 or 16)
//   Parity_error out  1   last received parity bit mismatched
//   Data_valid   out  1   one-cycle pulse, P_Data holds a new good byte
//   P_Data       out  DATA_WIDTH  last good received byte
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN : when defined, each bit is the 2-of-3 majority
//   of the samples at edge counts Prescale/2-1, Prescale/2, Prescale/2+1;
//   otherwise only the Prescale/2 sample is used.
//
// Sample alignment: the edge that detects the start bit is line cycle 0 of
// that bit, so the sample taken while edge_cnt_r == c is line cycle c+1 of
// the current bit. The decision edge is edge count Prescale/2+1.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic [4:0]            Prescale,
    output logic                  Parity_error,
    output logic                  Data_valid,
    output logic [DATA_WIDTH-1:0] P_Data
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_nx;
    logic [4:0]              edge_cnt_r;
    logic [BW-1:0]           bit_cnt_r;
    logic                    par_en_r;
    logic                    par_type_r;
    logic [4:0]              prescale_r;
    logic                    samp_mid_r;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic                    samp_lo_r;
`endif
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [DATA_WIDTH-1:0]   p_data_r;
    logic                    data_valid_r;
    logic                    parity_error_r;

    logic [4:0]              half_s;
    logic                    at_lo_s;
    logic                    at_mid_s;
    logic                    at_dec_s;
    logic                    at_wrap_s;
    logic                    bit_val_s;
    logic                    start_det_s;
    logic                    shift_en_s;
    logic                    perr_set_s;
    logic                    load_s;

    // XOR reduction of a data word (1 = odd number of ones)
    function automatic logic xor_reduce(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

`ifdef UART_RX_MAJORITY_VOTE_EN
    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Sample-point decode relative to the latched oversampling ratio
    always_comb begin
        half_s    = {1'b0, prescale_r[4:1]};
        at_lo_s   = (edge_cnt_r == (half_s - 5'd1));
        at_mid_s  = (edge_cnt_r == half_s);
        at_dec_s  = (edge_cnt_r == (half_s + 5'd1));
        at_wrap_s = (edge_cnt_r == (prescale_r - 5'd1));
`ifdef UART_RX_MAJORITY_VOTE_EN
        bit_val_s = majority3(samp_lo_r, samp_mid_r, S_Data);
`else
        bit_val_s = samp_mid_r;
`endif
    end

    // Next-state logic and per-edge action strobes
    always_comb begin
        state_nx    = state_r;
        start_det_s = 1'b0;
        shift_en_s  = 1'b0;
        perr_set_s  = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!S_Data) begin
                    state_nx    = START;
                    start_det_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                if (at_dec_s && bit_val_s) begin
                    state_nx = IDLE;            // glitch, not a real start bit
                end else if (at_wrap_s) begin
                    state_nx = DATA;
                end else begin
                    state_nx = START;
                end
            end
            DATA: begin
                shift_en_s = at_dec_s;
                if (at_wrap_s && (bit_cnt_r == LAST_BIT)) begin
                    state_nx = par_en_r ? PARITY : STOP;
                end else begin
                    state_nx = DATA;
                end
            end
            PARITY: begin
                perr_set_s = at_dec_s;
                if (at_wrap_s) begin
                    state_nx = STOP;
                end else begin
                    state_nx = PARITY;
                end
            end
            STOP: begin
                if (at_dec_s) begin
                    // Leave at mid-bit so a back-to-back start bit is caught
                    state_nx = IDLE;
                    load_s   = bit_val_s && !parity_error_r;
                end else begin
                    state_nx = STOP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Edge and bit counters
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            edge_cnt_r <= 5'd0;
            bit_cnt_r  <= '0;
        end else begin
            if ((state_r == IDLE) || (state_nx == IDLE) || at_wrap_s) begin
                edge_cnt_r <= 5'd0;
            end else begin
                edge_cnt_r <= edge_cnt_r + 5'd1;
            end
            if (state_r != DATA) begin
                bit_cnt_r <= '0;
            end else if (at_wrap_s) begin
                bit_cnt_r <= bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Frame configuration latched at start detection, and line samples
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            par_en_r   <= 1'b0;
            par_type_r <= 1'b0;
            prescale_r <= 5'd0;
            samp_mid_r <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            samp_lo_r  <= 1'b1;
`endif
        end else begin
            if (start_det_s) begin
                par_en_r   <= Parity_EN;
                par_type_r <= Parity_type;
                prescale_r <= Prescale;
            end
            if (at_mid_s) begin
                samp_mid_r <= S_Data;
            end
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (at_lo_s) begin
                samp_lo_r <= S_Data;
            end
`endif
        end
    end

    // Data shift register (LSB first) and registered outputs
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            shift_r        <= '0;
            p_data_r       <= '0;
            data_valid_r   <= 1'b0;
            parity_error_r <= 1'b0;
        end else begin
            if (shift_en_s) begin
                shift_r <= {bit_val_s, shift_r[DATA_WIDTH-1:1]};
            end
            data_valid_r <= load_s;
            if (load_s) begin
                p_data_r <= shift_r;
            end
            if (start_det_s) begin
                parity_error_r <= 1'b0;
            end else if (perr_set_s) begin
                parity_error_r <= xor_reduce(shift_r) ^ bit_val_s ^ par_type_r;
            end
        end
    end

`ifndef UART_RX_MAJORITY_VOTE_EN
    // Low sample point is only meaningful with majority voting
    logic unused_lo_s;
    assign unused_lo_s = at_lo_s;
`endif

    assign P_Data       = p_data_r;
    assign Data_valid   = data_valid_r;
    assign Parity_error = parity_error_r;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx
// Line bits are driven on falling clock edges; outputs are checked on
// falling edges. Data_valid high cycles are counted by a monitor.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    logic       CLK;
    logic       Reset;
    logic       S_Data;
    logic       Parity_EN;
    logic       Parity_type;
    logic [4:0] Prescale;
    logic       Parity_error;
    logic       Data_valid;
    logic [7:0] P_Data;

    int err_cnt = 0;
    int chk_cnt = 0;
    int dv_cnt  = 0;
    int dv_base;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .S_Data       (S_Data),
        .Parity_EN    (Parity_EN),
        .Parity_type  (Parity_type),
        .Prescale     (Prescale),
        .Parity_error (Parity_error),
        .Data_valid   (Data_valid),
        .P_Data       (P_Data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count cycles with Data_valid high
    always @(negedge CLK) begin
        if (Data_valid) dv_cnt = dv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One line bit of p cycles; cycle g (if in range) carries the inverse
    task automatic send_bit(input logic b, input int p, input int g);
        for (int i = 0; i < p; i++) begin
            S_Data = (i == g) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic p_en, input logic p_type,
                              input logic p_bit, input logic stop_bit, input int p,
                              input int g_bit, input int g_idx);
        Parity_EN   = p_en;
        Parity_type = p_type;
        Prescale    = 5'(p);
        send_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i], p, (i == g_bit) ? g_idx : -1);
        end
        if (p_en) send_bit(p_bit, p, -1);
        send_bit(stop_bit, p, -1);
        S_Data = 1'b1;
    endtask

    task automatic idle(input int n);
        S_Data = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        Reset       = 1'b0;
        S_Data      = 1'b1;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        Prescale    = 5'd8;
        repeat (3) @(negedge CLK);
        check_eq("rst_pdata", 32'(P_Data), 32'h00);
        check_eq("rst_dv",    32'(Data_valid), 32'h0);
        check_eq("rst_perr",  32'(Parity_error), 32'h0);
        Reset = 1'b1;
        idle(10);

        // Even parity, 0xAB (5 ones -> parity 1)
        dv_base = dv_cnt;
        send_frame(8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 8, -1, -1);
        check_eq("f1_pdata", 32'(P_Data), 32'hAB);
        check_eq("f1_dv",    32'(dv_cnt - dv_base), 32'd1);
        check_eq("f1_perr",  32'(Parity_error), 32'h0);

        // Back-to-back: 0xAA (4 ones) with parity 1 -> parity error
        dv_base = dv_cnt;
        send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 8, -1, -1);
        check_eq("f2_pdata", 32'(P_Data), 32'hAB);
        check_eq("f2_dv",    32'(dv_cnt - dv_base), 32'd0);
        check_eq("f2_perr",  32'(Parity_error), 32'h1);

        // Back-to-back: 0xAF (6 ones) with parity 0 -> good
        dv_base = dv_cnt;
        send_frame(8'hAF, 1'b1, 1'b0, 1'b0, 1'b1, 8, -1, -1);
        check_eq("f3_pdata", 32'(P_Data), 32'hAF);
        check_eq("f3_dv",    32'(dv_cnt - dv_base), 32'd1);
        check_eq("f3_perr",  32'(Parity_error), 32'h0);
        idle(16);

        // No parity, Prescale 16, 0x3C
        dv_base = dv_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        check_eq("p16_pdata", 32'(P_Data), 32'h3C);
        check_eq("p16_dv",    32'(dv_cnt - dv_base), 32'd1);
        check_eq("p16_perr",  32'(Parity_error), 32'h0);
        idle(16);

        // Start glitch: two low cycles then high
        dv_base = dv_cnt;
        S_Data = 1'b0;
        repeat (2) @(negedge CLK);
        idle(24);
        check_eq("glitch_dv", 32'(dv_cnt - dv_base), 32'd0);
        dv_base = dv_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1);
        check_eq("post_glitch_pdata", 32'(P_Data), 32'h5A);
        check_eq("post_glitch_dv",    32'(dv_cnt - dv_base), 32'd1);
        idle(16);

        // Odd parity, 0x0F (4 ones -> parity 1)
        dv_base = dv_cnt;
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 8, -1, -1);
        check_eq("odd_pdata", 32'(P_Data), 32'h0F);
        check_eq("odd_dv",    32'(dv_cnt - dv_base), 32'd1);
        check_eq("odd_perr",  32'(Parity_error), 32'h0);
        idle(16);

        // Framing error: stop bit 0
        dv_base = dv_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8, -1, -1);
        idle(24);
        check_eq("frm_pdata", 32'(P_Data), 32'h0F);
        check_eq("frm_dv",    32'(dv_cnt - dv_base), 32'd0);

        // Reset in the middle of DATA
        Parity_EN = 1'b0;
        Prescale  = 5'd8;
        send_bit(1'b0, 8, -1);
        send_bit(1'b1, 8, -1);
        send_bit(1'b1, 8, -1);
        send_bit(1'b1, 4, -1);
        Reset = 1'b0;
        #1;
        check_eq("midrst_pdata", 32'(P_Data), 32'h00);
        check_eq("midrst_dv",    32'(Data_valid), 32'h0);
        check_eq("midrst_perr",  32'(Parity_error), 32'h0);
        S_Data = 1'b1;
        @(negedge CLK);
        Reset = 1'b1;
        idle(16);
        dv_base = dv_cnt;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1);
        check_eq("post_rst_pdata", 32'(P_Data), 32'hC3);
        check_eq("post_rst_dv",    32'(dv_cnt - dv_base), 32'd1);
        idle(16);

        // Data bit 2 of 0x00: invert the early sample (line cycle 4)
        dv_base = dv_cnt;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2, 4);
        check_eq("vote_lo_pdata", 32'(P_Data), 32'h00);
        check_eq("vote_lo_dv",    32'(dv_cnt - dv_base), 32'd1);
        idle(16);

        // Data bit 2 of 0xFF: invert the centre sample (line cycle 5)
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2, 5);
`ifdef UART_RX_MAJORITY_VOTE_EN
        check_eq("vote_mid_pdata", 32'(P_Data), 32'hFF);
`else
        check_eq("vote_mid_pdata", 32'(P_Data), 32'hFB);
`endif
        idle(8);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: Uart_Rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; only 8 is required to be supported.
REQ-002 CLK  input  1  single clock; all logic rising-edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 S_Data  input  1  serial line; idles high; assumed synchronous to CLK.
REQ-005 Parity_EN  input  1  1 = frame carries a parity bit.
REQ-006 Parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-007 Prescale  input  5  CLK cycles per bit (oversampling ratio); legal values 8 and 16; other values unsupported.
REQ-008 Parity_error  output  1  1 = last received parity bit mismatched.
REQ-009 Data_valid  output  1  one-cycle pulse: P_Data holds a newly received, error-free byte.
REQ-010 P_Data  output  8  last good received byte.

Function
REQ-011 The frame SHALL be: start (0), 8 data bits LSB first (first data bit -> P_Data[0]), optional parity bit, one stop bit (1).
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, S_Data = 0 on a clock edge SHALL move the FSM to START with the edge counter cleared; Parity_EN, Parity_type and Prescale are latched at this edge for the whole frame.
REQ-014 An edge counter SHALL count 0..Prescale-1 within each bit, and a bit counter SHALL advance when the edge counter wraps.
REQ-015 Each bit value SHALL be decided from samples at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1 (see REQ-026).
REQ-016 START: if the decided bit is 1 (glitch), the FSM SHALL return to IDLE with no output change; otherwise it goes to DATA at the end of the bit.
REQ-017 DATA: after 8 bits, the FSM SHALL go to PARITY if the latched Parity_EN = 1, else to STOP.
REQ-018 PARITY: Parity_error SHALL be set to (XOR of the 8 data bits XOR the received parity bit XOR Parity_type) != 0, at the decision edge; it is held until the next start detection, which clears it.
REQ-019 STOP: at the decision edge the FSM SHALL return to IDLE. If the stop bit is 1 and there is no parity error, P_Data is loaded and Data_valid is high for exactly the next clock cycle.
REQ-020 A stop bit of 0 (framing error) or a parity error SHALL discard the frame: no Data_valid, and P_Data unchanged.
REQ-021 Because of REQ-019, a back-to-back start bit that immediately follows the stop bit SHALL be received.
REQ-022 With the latched Parity_EN = 0, Parity_error SHALL remain 0.

Reset
REQ-023 Reset low SHALL immediately force: FSM to IDLE, counters to 0, P_Data = 0, Data_valid = 0, Parity_error = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release, reception resumes only at the next falling edge seen in IDLE.
REQ-025 Reset release SHALL be synchronous-safe: the first active edge after deassertion operates normally.

Configuration
REQ-026 Macro UART_RX_MAJORITY_VOTE_EN: when defined, the bit value is the 2-of-3 majority of the three samples; when undefined, only the Prescale/2 sample is used and the other two are ignored.

Verification
REQ-027 Prescale = 8, Parity_EN = 1, even parity; line bits start 0, data 1,1,0,1,0,1,0,1, parity 1, stop 1 -> Data_valid one-cycle pulse, P_Data = 0xAB, Parity_error = 0.
REQ-028 Back-to-back frame after REQ-027: data 0,1,0,1,0,1,0,1, parity 1 -> Parity_error = 1, no Data_valid, P_Data stays 0xAB; a third frame with data 1,1,1,1,0,1,0,1, parity 0 -> P_Data = 0xAF, Data_valid pulse, Parity_error = 0.
REQ-029 Parity_EN = 0, Prescale = 16, 10-bit frame with data 0x3C -> P_Data = 0x3C, Data_valid pulse, Parity_error = 0.
REQ-030 S_Data low for 2 cycles then high (glitch) -> FSM returns to IDLE, no Data_valid; a valid frame that follows is received correctly.
REQ-031 Frame with stop bit 0 -> no Data_valid, P_Data unchanged; Reset pulsed low in the middle of the DATA state -> all outputs 0 immediately and the next full frame is received correctly.
REQ-032 With UART_RX_MAJORITY_VOTE_EN defined, one sample (edge Prescale/2-1) of a data bit inverted -> byte received unchanged; with the macro undefined, the same stimulus still passes, and inverting the Prescale/2 sample corrupts that bit.
